// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO burst reader: FSM state encodings and default burst length.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned BURST_LEN_DEF = 4;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order output buffer with valid/ready on both sides; exposes its occupancy
// so the reader can budget reads that are still in flight.
module fifo_out_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;
  assign occ     = cnt_q;
  // A full buffer can still take a beat in the same cycle the head leaves.
  assign s_ready = (cnt_q != 2'd2) || m_ready;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = s_data;
        else               tail_d = s_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = s_data;
        end else begin
          head_d = tail_q;
          tail_d = s_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the data entries are reset as well, so m_data reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= only; combinational blocks use =.
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from a single-clock FIFO and streams them out with m_last.
// Optional BURST_FLUSH_EN adds a flush input that starts a short burst from a partial FIFO.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BURST_FLUSH_EN
  input  logic              flush,
`endif
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             infl_q, infl_d;
  logic             infl_last_q, infl_last_d;

  logic             rd_en, last_rd;
  logic             sk_s_ready, sk_last;
  logic [1:0]       sk_occ;
  logic [1:0]       pending;

  // Beats that will sit in the buffer next cycle: what stays after this cycle's
  // transfer plus the read already in flight. A new read is only safe below two.
  assign pending = sk_occ - {1'b0, m_valid && m_ready} + {1'b0, infl_q};
  assign last_rd = (rd_cnt_q == len_q - ONE);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    rd_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count >= BURST_LEN_C) begin
          state_d  = ST_READ;
          len_d    = BURST_LEN_C;
          rd_cnt_d = '0;
        end
`ifdef BURST_FLUSH_EN
        else if (flush && !fifo_empty && (fifo_count != '0)) begin
          state_d  = ST_READ;
          len_d    = (fifo_count < BURST_LEN_C) ? fifo_count : BURST_LEN_C;
          rd_cnt_d = '0;
        end
`endif
      end
      ST_READ: begin
        if (!fifo_empty && (rd_cnt_q < len_q) && (pending < 2'd2)) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + ONE;
          if (last_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_valid && m_ready && m_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    infl_d      = rd_en;
    infl_last_d = rd_en && last_rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

  fifo_out_skid #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .s_valid (infl_q),
    .s_ready (sk_s_ready),
    .s_data  ({infl_last_q, fifo_dout}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  ({sk_last, m_data}),
    .occ     (sk_occ)
  );

  // The read budget guarantees every returning beat finds room in the buffer.
  assert property (@(posedge clk) disable iff (!rst) infl_q |-> sk_s_ready);

  assign fifo_rd_en = rd_en;
  assign m_last     = sk_last && m_valid;
  assign busy       = (state_q != ST_IDLE);

endmodule
